// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared constants and state encodings for the UART command controller.
// Holds the ASCII command/response bytes and both FSM enumerations.
package uart_cmd_ctrl_pkg;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_D  = 8'h44;
  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_Z  = 8'h5A;
  localparam logic [7:0] CH_Q  = 8'h3F;
  localparam logic [7:0] CH_1  = 8'h31;
  localparam logic [7:0] CH_2  = 8'h32;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_N  = 8'h4E;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam int RESP_MAX = 9;
  typedef logic [RESP_MAX-1:0][7:0] resp_buf_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ARG, ST_RESP} state_t;
  typedef enum logic [1:0] {SQ_IDLE, SQ_ISSUE, SQ_WRISE, SQ_WFALL} seq_state_t;
endpackage

// File: rtl/uart_cmd_ctrl_resp_seq.sv
// uart_resp_seq: buffers up to 9 response bytes and feeds them to uart_tx,
// one tx_en pulse per byte, waiting for busy to rise then fall between bytes.
module uart_resp_seq
  import uart_cmd_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  resp_buf_t  i_bytes,
  input  logic [3:0] i_len,
  input  logic       i_tx_busy,
  output logic       o_tx_en,
  output logic [7:0] o_tx_data,
  output logic       o_done
);
  seq_state_t r_state, w_state_nxt;
  resp_buf_t  r_buf;
  logic [3:0] r_len;
  logic [3:0] r_idx;
  logic       w_adv;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= SQ_IDLE;
      r_buf   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_load) begin
        r_buf <= i_bytes;
        r_len <= i_len;
        r_idx <= '0;
      end else if (w_adv) begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_tx_en     = 1'b0;
    o_done      = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      SQ_IDLE:  if (i_load) w_state_nxt = SQ_ISSUE;
      SQ_ISSUE: if (!i_tx_busy) begin
        o_tx_en     = 1'b1;
        w_state_nxt = SQ_WRISE;
      end
      SQ_WRISE: if (i_tx_busy) w_state_nxt = SQ_WFALL;
      SQ_WFALL: if (!i_tx_busy) begin
        if (r_idx == r_len - 4'd1) begin
          o_done      = 1'b1;
          w_state_nxt = SQ_IDLE;
        end else begin
          w_adv       = 1'b1;
          w_state_nxt = SQ_ISSUE;
        end
      end
      default: w_state_nxt = SQ_IDLE;
    endcase
  end

  assign o_tx_data = r_buf[r_idx];
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: one-cycle o_rx_done pulse with o_rx_data on a good stop bit.
// Bits are sampled near mid-bit after a two-flop synchronizer.
module uart_rx #(
  parameter int CLK_FREQ = 125000000,
  parameter int UART_BPS = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rxd,
  output logic       o_rx_done,
  output logic [7:0] o_rx_data
);
  localparam int DIV = CLK_FREQ / UART_BPS;
  localparam int CW  = $clog2(DIV + 1);

  logic [2:0]    r_sync;
  logic          r_active;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_done;
  logic [7:0]    r_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync   <= 3'b111;
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_done   <= 1'b0;
      r_data   <= '0;
    end else begin
      r_sync <= {r_sync[1:0], i_rxd};
      r_done <= 1'b0;
      if (!r_active) begin
        if (r_sync[2] && !r_sync[1]) begin
          r_active <= 1'b1;
          r_cnt    <= '0;
          r_bit    <= '0;
        end
      end else begin
        if (r_cnt == CW'(DIV - 1)) begin
          r_cnt <= '0;
          r_bit <= r_bit + 4'd1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        // a start bit that is high again at mid-bit was a glitch
        if (r_cnt == CW'(DIV / 2 - 1)) begin
          if (r_bit == 4'd0) begin
            if (r_sync[1]) r_active <= 1'b0;
          end else if (r_bit < 4'd9) begin
            r_shift <= {r_sync[1], r_shift[7:1]};
          end else begin
            r_active <= 1'b0;
            r_done   <= r_sync[1];
            r_data   <= r_shift;
          end
        end
      end
    end
  end

  assign o_rx_done = r_done;
  assign o_rx_data = r_data;
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: a one-cycle i_tx_en while idle sends one frame.
// o_tx_busy is high from the cycle after i_tx_en until the stop bit ends.
module uart_tx #(
  parameter int CLK_FREQ = 125000000,
  parameter int UART_BPS = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_en,
  input  logic [7:0] i_tx_data,
  output logic       o_txd,
  output logic       o_tx_busy
);
  localparam int DIV = CLK_FREQ / UART_BPS;
  localparam int CW  = $clog2(DIV + 1);

  logic          r_busy;
  logic          r_txd;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [9:0]    r_frame;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy  <= 1'b0;
      r_txd   <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_frame <= '1;
    end else if (!r_busy) begin
      if (i_tx_en) begin
        r_busy  <= 1'b1;
        r_frame <= {1'b1, i_tx_data, 1'b0};
        r_txd   <= 1'b0;
        r_cnt   <= '0;
        r_bit   <= '0;
      end
    end else if (r_cnt == CW'(DIV - 1)) begin
      r_cnt <= '0;
      if (r_bit == 4'd9) begin
        r_busy <= 1'b0;
        r_txd  <= 1'b1;
      end else begin
        r_bit   <= r_bit + 4'd1;
        r_frame <= {1'b1, r_frame[9:1]};
        r_txd   <= r_frame[1];
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_txd     = r_txd;
  assign o_tx_busy = r_busy;
endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command parser driving N_CH enable bits, answering with ACK/NAK/status.
// The parser FSM lives here; response transmission is delegated to uart_resp_seq.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int              CLK_FREQ    = 125000000,
  parameter int              UART_BPS    = 115200,
  parameter int              N_CH        = 4,
  parameter logic [N_CH-1:0] EN_RESET    = '0,
  parameter int              ARG_TIMEOUT = 125000000,
  parameter int              LEGACY      = 1
) (
  input  logic            sys_clk,
  input  logic            reset,
  input  logic            uart_rxd,
  output logic            uart_txd,
  output logic [N_CH-1:0] en,
  output logic            cmd_err,
  output logic            busy
);
  localparam int TW = $clog2(ARG_TIMEOUT + 1);

  logic            w_rx_done, w_tx_en, w_tx_busy, w_seq_done;
  logic [7:0]      w_rx_data, w_tx_data;
  logic            w_load, w_err, w_arg_ok, w_timeout;
  logic [3:0]      w_len;
  resp_buf_t       w_bytes;
  state_t          r_state, w_state_nxt;
  logic [N_CH-1:0] r_en, w_en_nxt;
  logic            r_op_e, w_op_e_nxt;
  logic            r_cmd_err;
  logic [TW-1:0]   r_tcnt;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) u_rx (
    .i_clk(sys_clk), .i_rst_n(reset), .i_rxd(uart_rxd),
    .o_rx_done(w_rx_done), .o_rx_data(w_rx_data)
  );

  uart_tx #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) u_tx (
    .i_clk(sys_clk), .i_rst_n(reset), .i_tx_en(w_tx_en), .i_tx_data(w_tx_data),
    .o_txd(uart_txd), .o_tx_busy(w_tx_busy)
  );

  uart_resp_seq u_seq (
    .i_clk(sys_clk), .i_rst_n(reset), .i_load(w_load), .i_bytes(w_bytes),
    .i_len(w_len), .i_tx_busy(w_tx_busy), .o_tx_en(w_tx_en),
    .o_tx_data(w_tx_data), .o_done(w_seq_done)
  );

  // ASCII '0'..'7' whose value addresses an existing channel
  assign w_arg_ok  = (w_rx_data[7:3] == 5'b00110) && (int'(w_rx_data[2:0]) < N_CH);
  assign w_timeout = (r_tcnt == TW'(ARG_TIMEOUT - 1));

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_en      <= EN_RESET;
      r_op_e    <= 1'b0;
      r_cmd_err <= 1'b0;
      r_tcnt    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_en      <= w_en_nxt;
      r_op_e    <= w_op_e_nxt;
      r_cmd_err <= w_err;
      r_tcnt    <= (r_state == ST_ARG) ? r_tcnt + 1'b1 : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = r_en;
    w_op_e_nxt  = r_op_e;
    w_load      = 1'b0;
    w_len       = 4'd1;
    w_bytes     = '0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: if (w_rx_done) begin
        w_state_nxt = ST_RESP;
        w_load      = 1'b1;
        w_bytes[0]  = CH_K;
        if (w_rx_data == CH_E || w_rx_data == CH_D) begin
          w_op_e_nxt  = (w_rx_data == CH_E);
          w_state_nxt = ST_ARG;
          w_load      = 1'b0;
        end else if (w_rx_data == CH_A || (LEGACY != 0 && w_rx_data == CH_1)) begin
          w_en_nxt = '1;
        end else if (w_rx_data == CH_Z || (LEGACY != 0 && w_rx_data == CH_2)) begin
          w_en_nxt = '0;
        end else if (w_rx_data == CH_Q) begin
          for (int i = 0; i < N_CH; i++) w_bytes[i] = r_en[N_CH-1-i] ? CH_1 : CH_0;
          w_bytes[N_CH] = CH_CR;
          w_len         = 4'(N_CH + 1);
        end else begin
          w_bytes[0] = CH_N;
          w_err      = 1'b1;
        end
      end
      // an argument byte arriving on the timeout cycle wins over the timeout
      ST_ARG: if (w_rx_done || w_timeout) begin
        w_state_nxt = ST_RESP;
        w_load      = 1'b1;
        w_bytes[0]  = CH_N;
        w_err       = 1'b1;
        if (w_rx_done && w_arg_ok) begin
          w_bytes[0] = CH_K;
          w_err      = 1'b0;
          for (int i = 0; i < N_CH; i++)
            if (int'(w_rx_data[2:0]) == i) w_en_nxt[i] = r_op_e;
        end
      end
      ST_RESP: begin
        w_err = w_rx_done;
        if (w_seq_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign en      = r_en;
  assign cmd_err = r_cmd_err;
  assign busy    = (r_state != ST_IDLE);
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed and randomized bench for uart_cmd_ctrl with a command-level reference model.
module tb_uart_cmd_ctrl;
  localparam int CLK_FREQ = 1000000;
  localparam int UART_BPS = 100000;
  localparam int DIV      = CLK_FREQ / UART_BPS;
  localparam int N_CH     = 4;
  localparam int ARG_TO   = 2000;

  logic            sys_clk = 1'b0;
  logic            reset   = 1'b0;
  logic            uart_rxd = 1'b1;
  logic            uart_txd;
  logic [N_CH-1:0] en;
  logic            cmd_err;
  logic            busy;

  int         checks = 0;
  int         errors = 0;
  int         err_total = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  int         exp_err;
  logic [N_CH-1:0] en_m;
  logic [7:0] mon_b;

  uart_cmd_ctrl #(
    .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .N_CH(N_CH),
    .EN_RESET('0), .ARG_TIMEOUT(ARG_TO), .LEGACY(1)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .en(en), .cmd_err(cmd_err), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) if (cmd_err === 1'b1) err_total <= err_total + 1;

  // serial decoder for the response line
  initial begin
    forever begin
      @(negedge sys_clk);
      if (uart_txd === 1'b0) begin
        repeat (DIV / 2) @(negedge sys_clk);
        if (uart_txd === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge sys_clk);
            mon_b[i] = uart_txd;
          end
          repeat (DIV) @(negedge sys_clk);
          if (uart_txd === 1'b1) tx_q.push_back(mon_b);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = fr[i];
      repeat (DIV) @(negedge sys_clk);
    end
    repeat (gap) @(negedge sys_clk);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (n < bound && busy !== 1'b0) begin
      @(negedge sys_clk);
      n++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  // reference behaviour of one complete command (has_arg=0 on E/D means timeout)
  task automatic model(input logic [7:0] op, input logic [7:0] arg, input bit has_arg);
    int v;
    exp_q.delete();
    exp_err = 0;
    v = int'(arg) - 48;
    if (op == "E" || op == "D") begin
      if (has_arg && v >= 0 && v < N_CH) begin
        en_m[v] = (op == "E");
        exp_q.push_back("K");
      end else begin
        exp_q.push_back("N");
        exp_err = 1;
      end
    end else if (op == "A" || op == "1") begin
      en_m = '1;
      exp_q.push_back("K");
    end else if (op == "Z" || op == "2") begin
      en_m = '0;
      exp_q.push_back("K");
    end else if (op == "?") begin
      for (int i = N_CH - 1; i >= 0; i--) exp_q.push_back(en_m[i] ? "1" : "0");
      exp_q.push_back(8'h0D);
    end else begin
      exp_q.push_back("N");
      exp_err = 1;
    end
  endtask

  task automatic check_resp(input string tag, input int base, input int err0);
    int idx;
    chk({tag, "_len"}, 32'(tx_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      idx = base + i;
      chk($sformatf("%s_byte%0d", tag, i), (idx < tx_q.size()) ? {24'd0, tx_q[idx]} : 32'hDEAD,
          {24'd0, exp_q[i]});
    end
    chk({tag, "_en"}, {28'd0, en}, {28'd0, en_m});
    chk({tag, "_err"}, 32'(err_total - err0), 32'(exp_err));
  endtask

  task automatic do_cmd(input string tag, input logic [7:0] op, input logic [7:0] arg,
                        input bit has_arg);
    int base, err0;
    base = tx_q.size();
    err0 = err_total;
    model(op, arg, has_arg);
    send_byte(op, has_arg ? 0 : 2);
    if (has_arg) send_byte(arg, 2);
    wait_idle(tag, 5000);
    repeat (3) @(negedge sys_clk);
    check_resp(tag, base, err0);
  endtask

  initial begin
    int base, err0, r;
    logic [7:0] op, arg;
    logic [7:0] ops[9];
    ops = '{"E", "D", "A", "Z", "?", "1", "2", "X", "D"};
    en_m = '0;

    repeat (5) @(negedge sys_clk);
    @(posedge sys_clk); #1;
    chk("rst_en", {28'd0, en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_txd", {31'd0, uart_txd}, 32'd1);
    chk("rst_err", {31'd0, cmd_err}, 32'd0);
    @(negedge sys_clk);
    reset = 1'b1;
    repeat (20) @(negedge sys_clk);

    do_cmd("set2", "E", "2", 1);
    do_cmd("set0", "E", "0", 1);
    do_cmd("status", "?", 8'h00, 0);
    do_cmd("clr7", "D", "7", 1);
    do_cmd("badop", "X", 8'h00, 0);
    do_cmd("timeout", "E", 8'h00, 0);
    do_cmd("all", "A", 8'h00, 0);
    do_cmd("zero", "Z", 8'h00, 0);

    // '?' lands while 'K' is still on the line and must be dropped
    base = tx_q.size();
    err0 = err_total;
    model("1", 8'h00, 0);
    exp_err = 1;
    send_byte("1", 0);
    send_byte("?", 2);
    wait_idle("drop", 5000);
    repeat (3) @(negedge sys_clk);
    check_resp("drop", base, err0);

    // reset in the middle of a status response
    send_byte("?", 2);
    repeat (150) @(negedge sys_clk);
    reset = 1'b0;
    @(posedge sys_clk); #1;
    chk("mrst_en", {28'd0, en}, 32'd0);
    chk("mrst_txd", {31'd0, uart_txd}, 32'd1);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    @(negedge sys_clk);
    reset = 1'b1;
    en_m = '0;
    repeat (200) @(negedge sys_clk);
    do_cmd("post_rst", "E", "0", 1);

    for (int k = 0; k < 14; k++) begin
      r   = $urandom_range(0, 8);
      op  = ops[r];
      arg = 8'h30 + 8'($urandom_range(0, 9));
      do_cmd($sformatf("rnd%0d", k), op, arg, (op == "E" || op == "D"));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
